// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_pkg
// Description : Shared types and constants for the USB full-speed TX path.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SYNC_LD  = 4'd1,
        SYNC     = 4'd2,
        PID_LD   = 4'd3,
        PID      = 4'd4,
        DATA_REQ = 4'd5,
        DATA_LD  = 4'd6,
        DATA     = 4'd7,
        CRC1_LD  = 4'd8,
        CRC1     = 4'd9,
        CRC2_LD  = 4'd10,
        CRC2     = 4'd11,
        EOP      = 4'd12,
        DONE     = 4'd13,
        ERR      = 4'd14
    } tx_state_t;

    localparam logic [3:0]  PID_DATA0    = 4'b0011;
    localparam logic [3:0]  PID_DATA1    = 4'b1011;
    localparam logic [3:0]  PID_ACK      = 4'b0010;
    localparam logic [3:0]  PID_NAK      = 4'b1010;
    localparam logic [3:0]  PID_STALL    = 4'b1110;

    localparam logic [15:0] CRC16_POLY_R = 16'hA001;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    function automatic logic is_valid_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1) || (pid == PID_ACK) ||
               (pid == PID_NAK)   || (pid == PID_STALL);
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ============================================================================
// Module      : usb_crc16
// Description : Byte-wide USB CRC16 register (reflected form, LSB first).
// Revision    : 1.0 - initial release
// ============================================================================
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC16_POLY_R;
            else             c = c >> 1;
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)     r_crc <= CRC16_INIT;
        else if (clear) r_crc <= CRC16_INIT;
        else if (en)    r_crc <= crc_byte(r_crc, data);
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_tx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_pkt_ctrl
// Description : Sequences SYNC/PID/payload/CRC16/EOP into the TX shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_pkt_ctrl
    import usb_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 64,
    parameter int         OCC_W       = 7,
    parameter logic [7:0] SYNC_BYTE   = 8'h80,
    parameter int         EOP_CYCLES  = 2
)(
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       tx_packet,
    input  logic [7:0]       tx_packet_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic             byte_sent,
    output logic             load_enable,
    output logic [7:0]       parallel_in,
    output logic             get_tx_packet_data,
    output logic             enable_timer,
    output logic             tx_transfer_active,
    output logic             eop_flag,
    output logic             tx_error,
    output logic             tx_done
);

    localparam int CNT_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int ECNT_W = $clog2(EOP_CYCLES + 1);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [3:0]        r_pid;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [ECNT_W-1:0] r_eop_cnt;
    logic [15:0]       w_crc;
    logic              w_occ_empty;

    assign w_occ_empty = (buffer_occupancy == '0);

    usb_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (r_state == PID_LD),
        .en    (r_state == DATA_LD),
        .data  (tx_packet_data),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pid      <= '0;
            r_byte_cnt <= '0;
            r_eop_cnt  <= '0;
        end else begin
            if (r_state == IDLE && is_valid_pid(tx_packet))
                r_pid <= tx_packet;
            if (r_state == PID_LD)
                r_byte_cnt <= '0;
            else if (r_state == DATA_LD)
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            // Counter is armed on entry so EOP lasts exactly EOP_CYCLES cycles.
            if (r_state != EOP && w_next == EOP)
                r_eop_cnt <= ECNT_W'(EOP_CYCLES - 1);
            else if (r_state == EOP && r_eop_cnt != '0)
                r_eop_cnt <= r_eop_cnt - ECNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (tx_packet != 4'd0)
                    w_next = is_valid_pid(tx_packet) ? SYNC_LD : ERR;
            end
            SYNC_LD:  w_next = SYNC;
            SYNC:     if (byte_sent) w_next = PID_LD;
            PID_LD:   w_next = PID;
            PID: begin
                if (byte_sent) begin
                    if (!is_data_pid(r_pid)) w_next = EOP;
                    else if (w_occ_empty)    w_next = CRC1_LD;
                    else                     w_next = DATA_REQ;
                end
            end
            DATA_REQ: w_next = DATA_LD;
            DATA_LD:  w_next = DATA;
            DATA: begin
                if (byte_sent) begin
                    if (w_occ_empty)                            w_next = CRC1_LD;
                    else if (r_byte_cnt == CNT_W'(MAX_PAYLOAD)) w_next = ERR;
                    else                                        w_next = DATA_REQ;
                end
            end
            CRC1_LD:  w_next = CRC1;
            CRC1:     if (byte_sent) w_next = CRC2_LD;
            CRC2_LD:  w_next = CRC2;
            CRC2:     if (byte_sent) w_next = EOP;
            EOP:      if (r_eop_cnt == '0) w_next = DONE;
            DONE:     w_next = IDLE;
            ERR:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        load_enable        = 1'b0;
        parallel_in        = 8'h00;
        get_tx_packet_data = 1'b0;
        enable_timer       = 1'b0;
        eop_flag           = 1'b0;
        tx_error           = 1'b0;
        tx_done            = 1'b0;
        tx_transfer_active = (r_state != IDLE);
        unique case (r_state)
            SYNC_LD:  begin load_enable = 1'b1; parallel_in = SYNC_BYTE;         end
            PID_LD:   begin load_enable = 1'b1; parallel_in = {~r_pid, r_pid};   end
            DATA_LD:  begin load_enable = 1'b1; parallel_in = tx_packet_data;    end
            CRC1_LD:  begin load_enable = 1'b1; parallel_in = ~w_crc[7:0];       end
            CRC2_LD:  begin load_enable = 1'b1; parallel_in = ~w_crc[15:8];      end
            DATA_REQ: get_tx_packet_data = 1'b1;
            SYNC, PID, DATA, CRC1, CRC2: enable_timer = 1'b1;
            EOP:      begin enable_timer = 1'b1; eop_flag = 1'b1; end
            DONE:     tx_done  = 1'b1;
            ERR:      tx_error = 1'b1;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_pkt_ctrl
// Description : Directed + randomized bench with a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_pkt_ctrl;

    localparam int MAXP = 4;
    localparam int OCCW = 7;
    localparam int EOPC = 2;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [3:0]      tx_packet = 4'd0;
    logic [7:0]      tx_packet_data = 8'd0;
    logic [OCCW-1:0] buffer_occupancy = '0;
    logic            byte_sent = 1'b0;
    logic            load_enable, get_tx_packet_data, enable_timer;
    logic            tx_transfer_active, eop_flag, tx_error, tx_done;
    logic [7:0]      parallel_in;

    always #5 clk = ~clk;

    usb_tx_pkt_ctrl #(
        .MAX_PAYLOAD (MAXP),
        .OCC_W       (OCCW),
        .SYNC_BYTE   (8'h80),
        .EOP_CYCLES  (EOPC)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .byte_sent          (byte_sent),
        .load_enable        (load_enable),
        .parallel_in        (parallel_in),
        .get_tx_packet_data (get_tx_packet_data),
        .enable_timer       (enable_timer),
        .tx_transfer_active (tx_transfer_active),
        .eop_flag           (eop_flag),
        .tx_error           (tx_error),
        .tx_done            (tx_done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] loads_q[$];
    int bs_wait, n_get, n_eop, n_done, n_err, n_active, hold_occ;
    int cyc, last_bs_drive, first_eop, last_eop, done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // USB CRC16 as a bit-serial LFSR (x16+x15+x2+1) over the wire bit order.
    function automatic logic [15:0] wire_crc(input logic [7:0] b[$]);
        logic [15:0] s;
        logic [15:0] r;
        logic        fb;
        s = 16'hFFFF;
        foreach (b[k])
            for (int i = 0; i < 8; i++) begin
                fb = b[k][i] ^ s[15];
                s  = {s[14:0], 1'b0};
                if (fb) s = s ^ 16'h8005;
            end
        s = ~s;
        for (int i = 0; i < 16; i++) r[i] = s[15-i];
        return r;
    endfunction

    task automatic clear_counters();
        loads_q.delete();
        bs_wait = 0; n_get = 0; n_eop = 0; n_done = 0; n_err = 0; n_active = 0;
        last_bs_drive = -10; first_eop = -1; last_eop = -1; done_cyc = -1;
    endtask

    // One clock: sample outputs at the falling edge, then act as shift register and FIFO.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (load_enable) begin
            loads_q.push_back(parallel_in);
            bs_wait = $urandom_range(2, 5);
        end
        if (get_tx_packet_data) n_get++;
        if (eop_flag) begin
            n_eop++;
            if (first_eop < 0) first_eop = cyc;
            last_eop = cyc;
        end
        if (tx_done) begin n_done++; done_cyc = cyc; end
        if (tx_error) n_err++;
        if (tx_transfer_active) n_active++;
        byte_sent = 1'b0;
        if (bs_wait > 0) begin
            bs_wait--;
            if (bs_wait == 0) begin byte_sent = 1'b1; last_bs_drive = cyc; end
        end
        if (get_tx_packet_data)
            tx_packet_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'($urandom);
        buffer_occupancy = (hold_occ >= 0) ? OCCW'(hold_occ) : OCCW'(fifo_q.size());
    endtask

    task automatic run_pkt(input string tag, input logic [3:0] pid, input int hold);
        logic [7:0]  exp_q[$];
        logic [15:0] c;
        bit          valid, dpid, ovf, exp_done;
        int          exp_get, budget, n;
        valid = pid inside {4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110};
        dpid  = pid inside {4'b0011, 4'b1011};
        ovf   = valid && dpid && hold >= 0 && pl_q.size() > MAXP;
        exp_done = valid && !ovf;
        exp_get  = 0;
        if (valid) begin
            exp_q.push_back(8'h80);
            exp_q.push_back({~pid, pid});
            if (dpid) begin
                n = ovf ? MAXP : pl_q.size();
                for (int i = 0; i < n; i++) exp_q.push_back(pl_q[i]);
                exp_get = n;
                if (!ovf) begin
                    c = wire_crc(pl_q);
                    exp_q.push_back(c[7:0]);
                    exp_q.push_back(c[15:8]);
                end
            end
        end
        clear_counters();
        fifo_q = pl_q;
        hold_occ = hold;
        buffer_occupancy = (hold >= 0) ? OCCW'(hold) : OCCW'(fifo_q.size());
        tx_packet = pid;
        step();
        tx_packet = 4'd0;
        if (valid) check({tag, " start_load"}, {31'd0, load_enable}, 32'd1);
        else       check({tag, " err_next"}, {31'd0, tx_error}, 32'd1);
        budget = 0;
        while (n_done + n_err == 0 && budget < 500) begin step(); budget++; end
        check({tag, " no_timeout"}, {31'd0, (budget < 500)}, 32'd1);
        step();
        check({tag, " back_idle"}, {31'd0, tx_transfer_active}, 32'd0);
        check({tag, " n_loads"}, loads_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < loads_q.size(); i++)
            check($sformatf("%s load%0d", tag, i), {24'd0, loads_q[i]}, {24'd0, exp_q[i]});
        check({tag, " n_get"}, n_get, exp_get);
        check({tag, " n_eop"}, n_eop, exp_done ? EOPC : 0);
        check({tag, " n_done"}, n_done, exp_done ? 1 : 0);
        check({tag, " n_err"}, n_err, exp_done ? 0 : 1);
        if (exp_done) begin
            check({tag, " eop_after_bs"}, first_eop, last_bs_drive + 1);
            check({tag, " done_after_eop"}, done_cyc, last_eop + 1);
        end
        if (!valid) check({tag, " active_cycles"}, n_active, 1);
    endtask

    logic [3:0] good_pids[5];
    logic [3:0] bad_pids[4];

    initial begin
        int budget;
        logic [3:0] pid;
        cyc = 0;
        hold_occ = -1;
        clear_counters();
        good_pids = '{4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110};
        bad_pids  = '{4'b0101, 4'b0001, 4'b1001, 4'b1111};

        repeat (3) step();
        check("reset outputs",
              {22'd0, load_enable, parallel_in, get_tx_packet_data, enable_timer,
               tx_transfer_active, eop_flag, tx_error, tx_done}, 32'd0);
        n_rst = 1'b1;
        step();

        pl_q.delete();
        run_pkt("ack", 4'b0010, -1);
        run_pkt("data1_zlp", 4'b1011, -1);
        pl_q = '{8'h01, 8'h02, 8'h03};
        run_pkt("data0_3b", 4'b0011, -1);

        for (int p = 0; p < 8; p++) begin
            pid = good_pids[$urandom_range(0, 4)];
            pl_q.delete();
            for (int i = 0; i < int'($urandom_range(0, MAXP)); i++) pl_q.push_back(8'($urandom));
            run_pkt($sformatf("rnd%0d", p), pid, -1);
        end

        pl_q.delete();
        for (int i = 0; i < 6; i++) pl_q.push_back(8'($urandom));
        run_pkt("overflow", 4'b0011, 10);

        pl_q.delete();
        foreach (bad_pids[i]) run_pkt($sformatf("badpid%0d", i), bad_pids[i], -1);

        // Reset while a data byte is being shifted out.
        clear_counters();
        pl_q = '{8'h11, 8'h22, 8'h33};
        fifo_q = pl_q;
        hold_occ = -1;
        buffer_occupancy = OCCW'(3);
        tx_packet = 4'b0011;
        step();
        tx_packet = 4'd0;
        budget = 0;
        while (!(loads_q.size() >= 3 && enable_timer) && budget < 200) begin step(); budget++; end
        check("rst_mid reached_data", {31'd0, (budget < 200)}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("rst_mid outputs",
              {22'd0, load_enable, parallel_in, get_tx_packet_data, enable_timer,
               tx_transfer_active, eop_flag, tx_error, tx_done}, 32'd0);
        bs_wait = 0;
        byte_sent = 1'b0;
        fifo_q.delete();
        n_err = 0;
        n_done = 0;
        repeat (3) step();
        check("rst_mid no_err", n_err, 0);
        check("rst_mid no_done", n_done, 0);
        n_rst = 1'b1;
        step();
        pl_q.delete();
        run_pkt("nak_after_rst", 4'b1010, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_pkt_ctrl.md
# usb_tx_pkt_ctrl

Parametrised packet controller for the USB full-speed transmitter. It sequences SYNC, PID, payload and CRC16 bytes into the TX shift register via `load_enable`/`parallel_in`. It computes the real CRC16 over the payload, supports zero-length data packets, enforces a maximum payload size, rejects undefined PIDs before any bus activity, and drives a configurable-length EOP. It sits between the AHB-side TX FIFO and the TX timer/shift-register/encoder chain.

## Interface
Parameters:
- `MAX_PAYLOAD`, 64: maximum number of data bytes per packet.
- `OCC_W`, 7: width of `buffer_occupancy`.
- `SYNC_BYTE`, 8'h80: SYNC pattern loaded into the shift register.
- `EOP_CYCLES`, 2: number of cycles `eop_flag` is held; must be ≥1.

Ports (one clock `clk`; reset `n_rst` is asynchronous and active-low):
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `tx_packet`  in  4  PID code; nonzero in IDLE starts a packet.
- `tx_packet_data`  in  8  FIFO byte; valid the cycle after `get_tx_packet_data`.
- `buffer_occupancy`  in  OCC_W  TX FIFO byte count.
- `byte_sent`  in  1  one-cycle pulse from the shift register; the current byte is finished.
- `load_enable`  out  1  loads `parallel_in` into the shift register.
- `parallel_in`  out  8  byte to load.
- `get_tx_packet_data`  out  1  one-cycle FIFO pop.
- `enable_timer`  out  1  bit timer runs.
- `tx_transfer_active`  out  1  high whenever the state is not IDLE.
- `eop_flag`  out  1  encoder drives SE0.
- `tx_error`  out  1  one-cycle error pulse.
- `tx_done`  out  1  one-cycle successful-completion pulse.

## Operation
- Moore FSM with states IDLE, SYNC_LD, SYNC, PID_LD, PID, DATA_REQ, DATA_LD, DATA, CRC1_LD, CRC1, CRC2_LD, CRC2, EOP, DONE, ERR.
- IDLE, when `tx_packet` != 0:
  - If the code is DATA0 (0011), DATA1 (1011), ACK (0010), NAK (1010) or STALL (1110), latch it into `pid_q` and go to SYNC_LD.
  - Any other nonzero code goes to ERR.
  - `tx_packet` is ignored outside IDLE.
- Byte sequence:
  - SYNC_LD loads `SYNC_BYTE`, then SYNC waits for `byte_sent`.
  - PID_LD loads {~pid_q, pid_q}, then PID waits for `byte_sent`.
- Leaving PID on `byte_sent`:
  - Handshake PID goes to EOP.
  - Data PID with occupancy 0 goes to CRC1_LD (zero-length packet).
  - Data PID otherwise goes to DATA_REQ.
- Payload loop:
  - DATA_REQ asserts `get_tx_packet_data` and goes to DATA_LD.
  - DATA_LD loads `tx_packet_data`, updates the CRC, increments `byte_cnt` and goes to DATA.
  - DATA on `byte_sent`: occupancy 0 goes to CRC1_LD; else `byte_cnt` == MAX_PAYLOAD goes to ERR; else DATA_REQ.
- CRC: USB CRC16, reflected polynomial 0xA001, register cleared to 16'hFFFF in PID_LD, byte-wise LSB-first update.
  - CRC1_LD loads ~crc[7:0] and CRC2_LD loads ~crc[15:8].
  - CRC1 goes to CRC2_LD on `byte_sent`; CRC2 goes to EOP on `byte_sent`.
- EOP holds `eop_flag` for `EOP_CYCLES` cycles using the down-counter `eop_cnt`, then goes to DONE.
- DONE pulses `tx_done` and goes to IDLE. ERR pulses `tx_error` and goes to IDLE.
- `load_enable` is high only in *_LD states; `parallel_in` is 0 elsewhere.
- `enable_timer` is high in SYNC, PID, DATA, CRC1, CRC2 and EOP.
- `byte_cnt` width is $clog2(MAX_PAYLOAD+1); it is cleared in PID_LD.

## Timing
- Reset: state IDLE, `pid_q`=0, crc=16'hFFFF, `byte_cnt`=0, `eop_cnt`=0; every output 0.
- Reset asserted mid-packet returns to IDLE immediately with no `tx_error` or `tx_done`.
- Start latency: `tx_packet` sampled in IDLE at edge N gives `load_enable` with SYNC in cycle N+1.
- Each *_LD state lasts exactly one cycle. `byte_sent` arriving in a *_LD state is ignored.
- `tx_packet_data` is sampled in DATA_LD, exactly one cycle after `get_tx_packet_data`.
- Handshake packet: the last `byte_sent` is followed by EOP_CYCLES cycles of `eop_flag`, then one cycle of `tx_done`.
- All outputs are decoded from registered state only. No combinational path from inputs to outputs except `parallel_in` from `tx_packet_data` in DATA_LD.

## Structure
- Package `usb_tx_pkg` holds:
  - the state enum `tx_state_t`;
  - PID localparams PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL;
  - CRC16_POLY_R = 16'hA001 and CRC16_INIT = 16'hFFFF;
  - the function `is_valid_pid`.
- Sub-module `usb_crc16`: a byte-wide CRC register with `clear`, `en` and `data` inputs and a `crc` output, so it can be reused by the RX CRC checker.

## Test plan
- ACK (0010) → loads 0x80 then 0xD2. After the second `byte_sent`, `eop_flag` is high for 2 cycles, then `tx_done` for 1 cycle, then IDLE.
- DATA1 (1011) with occupancy 0 → loads 0x80, 0x4B, 0x00, 0x00, then EOP. `get_tx_packet_data` never asserts.
- DATA0 (0011) with 3 FIFO bytes 0x01, 0x02, 0x03 → 3 `get_tx_packet_data` pulses. The bytes load in order, and the two CRC bytes match the software model.
- MAX_PAYLOAD=4 with occupancy held at 10 → after the 4th data `byte_sent`, `tx_error` pulses once and the FSM returns to IDLE with no EOP.
- `tx_packet`=0101 in IDLE → `tx_error` pulse the next cycle. No `load_enable`, and `tx_transfer_active` is high for exactly 1 cycle.
- `n_rst` low during DATA → all outputs 0 on the same cycle, and a subsequent NAK (1010) sends 0x80, 0x5A correctly.
